// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock-enable divider bank.
package clkdiv_pkg;

  localparam int CLKDIV_MIN_DIV = 2;
  localparam int CLKDIV_NCH     = 4;

  // Channel-select width; never below 1 so a single-channel bank still has a port.
  function automatic int clkdiv_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int CLKDIV_CHW = clkdiv_clog2(CLKDIV_NCH);

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: down-counter, active/shadow divisor with boundary apply,
// registered tick and square-enable outputs.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sync,
  input  logic         wr,
  input  logic [W-1:0] wr_div,
  output logic         pending,
  output logic         tick,
  output logic         sq
);

  localparam logic [W-1:0] MIN_DIV_W = W'(CLKDIV_MIN_DIV);
  localparam logic [W-1:0] DEF_DIV_W = W'(DEFAULT_DIV);
  localparam logic [W-1:0] ZERO_W    = {W{1'b0}};
  localparam logic [W-1:0] ONE_W     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_r, div_r, shadow_r;
  logic         pending_r, tick_r, sq_r;

  logic         run_s, boundary_s, apply_s, run_next_s;
  logic [W-1:0] div_next_s, cnt_next_s, shadow_next_s;
  logic         pending_next_s, tick_next_s, sq_next_s;

  // Next-state: boundary detection, divisor apply, counter and output decode.
  always_comb begin
    run_s      = en && (div_r >= MIN_DIV_W);
    // An idle channel is always at a boundary, so a pending write lands at once.
    boundary_s = !run_s || sync || (cnt_r == ZERO_W);
    apply_s    = boundary_s && pending_r;
    div_next_s = apply_s ? shadow_r : div_r;
    run_next_s = en && (div_next_s >= MIN_DIV_W);

    if (!run_next_s) begin
      cnt_next_s = ZERO_W;
    end else if (boundary_s) begin
      cnt_next_s = div_next_s - ONE_W;
    end else begin
      cnt_next_s = cnt_r - ONE_W;
    end

    tick_next_s = run_next_s && (cnt_next_s == ZERO_W);
    sq_next_s   = run_next_s && (cnt_next_s >= (div_next_s >> 1));

    // The top only grants a write when nothing is pending, so wr and apply never collide.
    if (wr) begin
      pending_next_s = 1'b1;
      shadow_next_s  = wr_div;
    end else begin
      pending_next_s = pending_r && !apply_s;
      shadow_next_s  = shadow_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= ZERO_W;
      div_r     <= DEF_DIV_W;
      shadow_r  <= DEF_DIV_W;
      pending_r <= 1'b0;
      tick_r    <= 1'b0;
      sq_r      <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      div_r     <= div_next_s;
      shadow_r  <= shadow_next_s;
      pending_r <= pending_next_s;
      tick_r    <= tick_next_s;
      sq_r      <= sq_next_s;
    end
  end

  assign pending = pending_r;
  assign tick    = tick_r;
  assign sq      = sq_r;

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of NCH runtime-programmable clock-enable dividers with a shared
// valid/ready config port and a global phase-align sync.
module clk_divider_bank
  import clkdiv_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCH-1:0]               en,
  input  logic                         sync,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [clkdiv_clog2(NCH)-1:0] cfg_ch,
  input  logic [W-1:0]                 cfg_div,
  output logic [NCH-1:0]               pending,
  output logic [NCH-1:0]               tick,
  output logic [NCH-1:0]               sq
);

  localparam int CHW = clkdiv_clog2(NCH);

  logic [NCH-1:0] sel_hit_s;
  logic [NCH-1:0] wr_s;

  // An out-of-range channel hits nothing, so the handshake completes and the write is dropped.
  assign cfg_ready = ~|(sel_hit_s & pending);

  genvar c;
  for (c = 0; c < NCH; c++) begin : g_ch
    assign sel_hit_s[c] = (cfg_ch == CHW'(c));
    assign wr_s[c]      = cfg_valid && cfg_ready && sel_hit_s[c];

    clkdiv_channel #(
      .W          (W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .en     (en[c]),
      .sync   (sync),
      .wr     (wr_s[c]),
      .wr_div (cfg_div),
      .pending(pending[c]),
      .tick   (tick[c]),
      .sq     (sq[c])
    );
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Scoreboard bench for clk_divider_bank: a phase-counting reference model
// predicts each cycle's outputs, which are queued and compared after the edge.
module tb_clk_divider_bank;
  import clkdiv_pkg::*;

  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int DEF = 2;
  localparam int CHW = CLKDIV_CHW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           sync = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  logic [W-1:0]   cfg_div = '0;
  logic [NCH-1:0] pending, tick, sq;

  clk_divider_bank #(.NCH(NCH), .W(W), .DEFAULT_DIV(DEF)) dut (
    .clk(clk), .reset(reset), .en(en), .sync(sync),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .pending(pending), .tick(tick), .sq(sq)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: age counts up from 0 after each period start; -1 style idle via m_alive.
  int m_div[NCH], m_shd[NCH], m_age[NCH];
  bit m_pend[NCH], m_alive[NCH];
  logic [3*NCH-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t got=%h want=%h", tag, $time, got, want);
    end
  endtask

  function automatic logic m_ready();
    int ch;
    ch = int'(cfg_ch);
    if (ch >= NCH) return 1'b1;
    return !m_pend[ch];
  endfunction

  function automatic logic [3*NCH-1:0] model_step();
    logic [NCH-1:0] et, es, ep;
    bit run_old, run_new, bnd, acc;
    int ch;
    et = '0; es = '0; ep = '0;
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = DEF; m_shd[i] = DEF; m_age[i] = 0;
        m_pend[i] = 1'b0; m_alive[i] = 1'b0;
      end
      return '0;
    end
    ch  = int'(cfg_ch);
    acc = cfg_valid && m_ready() && (ch < NCH);
    for (int i = 0; i < NCH; i++) begin
      run_old = en[i] && (m_div[i] >= 2);
      bnd = !run_old || sync || !m_alive[i] || (m_age[i] == m_div[i] - 1);
      if (bnd && m_pend[i]) begin
        m_div[i]  = m_shd[i];
        m_pend[i] = 1'b0;
      end
      run_new = en[i] && (m_div[i] >= 2);
      if (!run_new) begin
        m_alive[i] = 1'b0;
        m_age[i]   = 0;
      end else if (bnd) begin
        m_alive[i] = 1'b1;
        m_age[i]   = 0;
      end else begin
        m_age[i] = m_age[i] + 1;
      end
      et[i] = run_new && (m_age[i] == m_div[i] - 1);
      es[i] = run_new && (m_age[i] < (m_div[i] + 1) / 2);
    end
    if (acc) begin
      m_shd[ch]  = int'(cfg_div);
      m_pend[ch] = 1'b1;
    end
    for (int i = 0; i < NCH; i++) ep[i] = m_pend[i];
    return {et, es, ep};
  endfunction

  // One clock: check ready, predict, then compare registered outputs after the edge.
  task automatic cyc();
    logic [3*NCH-1:0] e;
    @(negedge clk);
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
    exp_q.push_back(model_step());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("tick", 32'(tick), 32'(e[3*NCH-1:2*NCH]));
    chk("sq", 32'(sq), 32'(e[2*NCH-1:NCH]));
    chk("pending", 32'(pending), 32'(e[NCH-1:0]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input int ch, input int d);
    bit done;
    done = 1'b0;
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_div   = W'(d);
    for (int i = 0; i < 64 && !done; i++) begin
      done = m_ready();
      cyc();
    end
    cfg_valid = 1'b0;
    chk("wr_done", 32'(done), 32'd1);
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
  endtask

  initial begin
    #1;
    run(2);
    reset = 1'b0;
    run(1);

    // Default divide-by-2 on channel 0 only.
    en = 4'b0001;
    run(8);

    // Program channel 1 while idle, then run it.
    wr(1, 5);
    en = 4'b0011;
    run(12);

    // Reprogram running channel 0 mid-period; a second write must wait.
    wr(0, 4);
    run(3);
    wr(0, 6);
    wr(0, 7);
    run(16);

    // Two channels phase-aligned by sync.
    wr(0, 4);
    wr(2, 6);
    en = 4'b0101;
    run(5);
    pulse_sync();
    run(14);

    // Stop a channel with D<2, then restart it with D=3.
    en = 4'b0111;
    run(3);
    wr(1, 1);
    run(8);
    wr(1, 3);
    run(8);
    wr(1, 0);
    run(4);

    // Reset while a write is pending.
    en = 4'b1111;
    run(2);
    wr(2, 9);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    run(10);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      en        = NCH'($urandom);
      sync      = ($urandom_range(0, 15) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CHW'($urandom_range(0, NCH - 1));
      cfg_div   = W'($urandom_range(0, 9));
      reset     = ($urandom_range(0, 149) == 0);
      cyc();
    end
    reset = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    run(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
